// File: rtl/xctcmsg_issue_queue.sv
// -----------------------------------------------------------------------------
// xctcmsg_issue_queue
//
// Decoupling FIFO between the RR stage and the xctcmsg functional unit. It
// holds fully-read XCTCMSG requests so that RR can keep issuing while the unit
// stalls on send/receive queue back-pressure. It also breaks the combinational
// ready path from the unit back into RR.
//
// Optional feature: define XCTCMSG_ISSUE_QUEUE_BYPASS_EN to make an empty,
// non-flushing queue transparent (0-cycle latency when out_ready is high).
// When the macro is undefined, every request spends at least one cycle in
// the storage array.
//
// Ports:
//   clk             - clock, all state updates on the rising edge
//   rst             - asynchronous active-high reset (pointers only)
//   flush           - pipeline flush, drops buffered and incoming requests
//   in_valid        - RR presents a request
//   in_ready        - queue accepts a request (depends only on occupancy)
//   in_funct3       - request funct3
//   in_rs1/in_rs2   - request operand values
//   in_passthrough  - execute-stage passthrough bundle
//   out_valid       - head request presented to xctcmsg
//   out_ready       - xctcmsg accepts the head request
//   out_funct3      - head funct3
//   out_rs1/out_rs2 - head operand values
//   out_passthrough - head passthrough bundle
//   occupancy       - number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------

package xctcmsg_issue_queue_pkg;
    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [7:0]  rob_tag;
    } exe_stage_passthrough_t;
endpackage

module xctcmsg_issue_queue
    import xctcmsg_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_funct3,
    input  logic [63:0]               in_rs1,
    input  logic [63:0]               in_rs2,
    input  exe_stage_passthrough_t    in_passthrough,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                out_funct3,
    output logic [63:0]               out_rs1,
    output logic [63:0]               out_rs2,
    output exe_stage_passthrough_t    out_passthrough,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = CNT_W - 1;

    typedef struct packed {
        logic [2:0]             funct3;
        logic [63:0]            rs1;
        logic [63:0]            rs2;
        exe_stage_passthrough_t pt;
    } entry_t;

    // Storage is data only; it is never reset.
    entry_t entry_q [DEPTH];

    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ;
    logic             empty;
    logic             push;
    logic             pop;
    entry_t           in_entry;
    entry_t           head;
    entry_t           out_entry;

    assign in_entry = {in_funct3, in_rs1, in_rs2, in_passthrough};

    // Pointers carry one extra MSB, so the modular difference distinguishes
    // full (DEPTH) from empty (0) with no extra state.
    assign occ       = wr_ptr_q - rd_ptr_q;
    assign occupancy = occ;
    assign empty     = (occ == '0);
    assign in_ready  = (occ != CNT_W'(DEPTH));
    assign head      = entry_q[rd_ptr_q[IDX_W-1:0]];

`ifdef XCTCMSG_ISSUE_QUEUE_BYPASS_EN
    // Empty queue is transparent. A request the unit takes immediately is
    // never written. One it does not take is stored as usual.
    assign out_valid = ~flush & (empty ? in_valid : 1'b1);
    assign out_entry = empty ? in_entry : head;
    assign pop       = out_valid & out_ready & ~empty;
    assign push      = in_valid & in_ready & ~flush & ~(empty & out_ready);
`else
    assign out_valid = ~empty & ~flush;
    assign out_entry = head;
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & in_ready & ~flush;
`endif

    assign {out_funct3, out_rs1, out_rs2, out_passthrough} = out_entry;

    // Flush wins over push and pop: collapse the read pointer onto the write
    // pointer so the queue is empty on the next cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) entry_q[wr_ptr_q[IDX_W-1:0]] <= in_entry;
    end

endmodule

// File: tb/tb_xctcmsg_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_xctcmsg_issue_queue
//
// Self-checking bench for xctcmsg_issue_queue. A queue-based reference model
// tracks the buffered requests; directed scenario tasks plus a randomized run
// compare the DUT outputs against it and against fixed expected constants.
// -----------------------------------------------------------------------------

module tb_xctcmsg_issue_queue;
    import xctcmsg_issue_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PT_W  = $bits(exe_stage_passthrough_t);

    typedef struct packed {
        logic [2:0]             f3;
        logic [63:0]            rs1;
        logic [63:0]            rs2;
        exe_stage_passthrough_t pt;
    } ent_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   flush = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [2:0]             in_funct3 = '0;
    logic [63:0]            in_rs1 = '0;
    logic [63:0]            in_rs2 = '0;
    exe_stage_passthrough_t in_passthrough = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [2:0]             out_funct3;
    logic [63:0]            out_rs1;
    logic [63:0]            out_rs2;
    exe_stage_passthrough_t out_passthrough;
    logic [CNT_W-1:0]       occupancy;

    int total = 0;
    int bad   = 0;

    ent_t mq[$];

    xctcmsg_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_funct3       (in_funct3),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_passthrough  (in_passthrough),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_funct3      (out_funct3),
        .out_rs1         (out_rs1),
        .out_rs2         (out_rs2),
        .out_passthrough (out_passthrough),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic ent_t cur_in();
        return {in_funct3, in_rs1, in_rs2, in_passthrough};
    endfunction

    function automatic ent_t got_out();
        return {out_funct3, out_rs1, out_rs2, out_passthrough};
    endfunction

    function automatic logic m_out_valid();
        if (flush) return 1'b0;
        if (mq.size() > 0) return 1'b1;
`ifdef XCTCMSG_ISSUE_QUEUE_BYPASS_EN
        return in_valid;
`else
        return 1'b0;
`endif
    endfunction

    function automatic ent_t m_head();
        if (mq.size() > 0) return mq[0];
        return cur_in();
    endfunction

    function automatic exe_stage_passthrough_t rand_pt();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return exe_stage_passthrough_t'(r[PT_W-1:0]);
    endfunction

    // Advance one clock; the model consumes the inputs seen at the edge.
    task automatic tick();
        int   n;
        bit   byp;
        ent_t e;
        @(posedge clk);
        n   = mq.size();
        byp = 1'b0;
        e   = cur_in();
        if (flush) begin
            mq.delete();
        end else begin
`ifdef XCTCMSG_ISSUE_QUEUE_BYPASS_EN
            if (n == 0 && in_valid && out_ready) byp = 1'b1;
`endif
            if (n > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && n != DEPTH && !byp) mq.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic [63:0] r1,
                         input logic [63:0] r2);
        in_valid       = v;
        in_funct3      = f3;
        in_rs1         = r1;
        in_rs2         = r2;
        in_passthrough = rand_pt();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst = 1'b1;
        #12;
        total++;
        if (occupancy !== '0) begin
            bad++; $display("FAIL reset_occ: got %0d want 0", occupancy);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        mq.delete();
    endtask

    task automatic test_single();
        ent_t exp;
        out_ready = 1'b1;
        drive(1'b1, 3'b001, 64'h1234, {$urandom(), $urandom()});
        exp = cur_in();
        #1;
`ifdef XCTCMSG_ISSUE_QUEUE_BYPASS_EN
        total++;
        if (out_valid !== 1'b1 || got_out() !== exp) begin
            bad++; $display("FAIL single_bypass: got v=%b %h want v=1 %h", out_valid, got_out(), exp);
        end
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (occupancy !== '0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL single_bypass_after: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid);
        end
`else
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL single_same_cycle: got v=%b want 0", out_valid);
        end
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1 || got_out() !== exp || occupancy !== 3'd1) begin
            bad++; $display("FAIL single_next: got v=%b occ=%0d %h want v=1 occ=1 %h", out_valid, occupancy, got_out(), exp);
        end
        tick();
        #1;
        total++;
        if (occupancy !== '0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL single_drained: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid);
        end
`endif
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 3'(i), 64'(i), 64'(i * 3));
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL fill_in_ready_%0d: got %b want 1", i, in_ready);
            end
            tick();
        end
        drive(1'b1, 3'd5, 64'd5, 64'd15);
        #1;
        total++;
        if (occupancy !== 3'd4 || in_ready !== 1'b0) begin
            bad++; $display("FAIL fill_full: got occ=%0d rdy=%b want occ=4 rdy=0", occupancy, in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (occupancy !== 3'd4) begin
            bad++; $display("FAIL fill_fifth_rejected: got occ=%0d want 4", occupancy);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            total++;
            if (out_valid !== 1'b1 || out_rs1 !== 64'(i) || got_out() !== m_head()) begin
                bad++; $display("FAIL fill_drain_%0d: got v=%b rs1=%0d want v=1 rs1=%0d", i, out_valid, out_rs1, i);
            end
            tick();
        end
        total++;
        if (occupancy !== '0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL fill_empty: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd2, 64'(i), 64'(i));
            tick();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (j + 2 < 10) drive(1'b1, 3'd2, 64'(j + 2), 64'(j + 2));
            else            in_valid = 1'b0;
            #1;
            total++;
            if (out_valid !== 1'b1 || out_rs1 !== 64'(j)) begin
                bad++; $display("FAIL wrap_order_%0d: got v=%b rs1=%0d want v=1 rs1=%0d", j, out_valid, out_rs1, j);
            end
            if (j < 8) begin
                total++;
                if (occupancy !== 3'd2) begin
                    bad++; $display("FAIL wrap_occ_%0d: got %0d want 2", j, occupancy);
                end
            end
            tick();
        end
        total++;
        if (occupancy !== '0) begin
            bad++; $display("FAIL wrap_drained: got %0d want 0", occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd4, 64'(100 + i), 64'(100 + i));
            tick();
        end
        drive(1'b1, 3'd7, 64'hBAD, 64'hBAD);
        flush = 1'b1;
        #1;
        total++;
        if (occupancy !== 3'd3 || out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_cycle: got occ=%0d v=%b want occ=3 v=0", occupancy, out_valid);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (occupancy !== '0 || out_valid !== 1'b0) begin
                bad++; $display("FAIL flush_after_%0d: got occ=%0d v=%b rs1=%h want occ=0 v=0", k, occupancy, out_valid, out_rs1);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd3, 64'(200 + i), 64'(200 + i));
            tick();
        end
        in_valid = 1'b0;
        #1;
        total++;
        if (occupancy !== 3'd2) begin
            bad++; $display("FAIL areset_pre_occ: got %0d want 2", occupancy);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (occupancy !== '0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL areset_immediate: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid);
        end
        mq.delete();
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || occupancy !== '0) begin
            bad++; $display("FAIL areset_release: got rdy=%b occ=%0d want rdy=1 occ=0", in_ready, occupancy);
        end
        tick();
    endtask

    task automatic test_stall();
        ent_t first;
        out_ready = 1'b0;
        drive(1'b1, 3'd6, 64'h77, 64'hDEAD);
        first = cur_in();
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 3'd1, {$urandom(), $urandom()}, {$urandom(), $urandom()});
            #1;
            total++;
            if (out_valid !== 1'b1 || out_rs2 !== 64'hDEAD || got_out() !== first) begin
                bad++; $display("FAIL stall_stable_%0d: got v=%b %h want v=1 %h", c, out_valid, got_out(), first);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < DEPTH; c++) tick();
        #1;
        total++;
        if (occupancy !== '0) begin
            bad++; $display("FAIL stall_drained: got %0d want 0", occupancy);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom()), {$urandom(), $urandom()}, {$urandom(), $urandom()});
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            total++;
            if (occupancy !== CNT_W'(mq.size()) || in_ready !== (mq.size() != DEPTH)) begin
                bad++; $display("FAIL rand_occ_%0d: got occ=%0d rdy=%b want occ=%0d", c, occupancy, in_ready, mq.size());
            end
            total++;
            if (out_valid !== m_out_valid()) begin
                bad++; $display("FAIL rand_valid_%0d: got %b want %b", c, out_valid, m_out_valid());
            end
            if (m_out_valid()) begin
                total++;
                if (got_out() !== m_head()) begin
                    bad++; $display("FAIL rand_data_%0d: got %h want %h", c, got_out(), m_head());
                end
            end
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_flush();
        test_async_reset();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xctcmsg_issue_queue.md
Name: xctcmsg_issue_queue

Overview:
- Decoupling FIFO between the RR stage and the xctcmsg functional unit. It sits directly upstream of the unit's rr_xctcmsg_* inputs.
- Buffers fully-read XCTCMSG requests (funct3, rs1, rs2, passthrough), so RR keeps issuing while the unit stalls on send/receive queue back-pressure.
- Drops all buffered requests on pipeline flush.
- Breaks the combinational ready path from the unit back into RR.

Parameters:
- DEPTH, 4, number of request entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count and of the read/write pointers (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  pipeline flush; discards every buffered and incoming request.
- in_valid  input  1  RR stage presents a request.
- in_ready  output  1  queue accepts the request this cycle.
- in_funct3  input  3  request funct3.
- in_rs1  input  64  request rs1 value.
- in_rs2  input  64  request rs2 value.
- in_passthrough  input  exe_stage_passthrough_t  execute-stage passthrough bundle.
- out_valid  output  1  head request presented to xctcmsg (rr_xctcmsg_valid).
- out_ready  input  1  xctcmsg accepts the head request (xctcmsg_rr_ready).
- out_funct3  output  3  head funct3.
- out_rs1  output  64  head rs1.
- out_rs2  output  64  head rs2.
- out_passthrough  output  exe_stage_passthrough_t  head passthrough.
- occupancy  output  CNT_W  number of valid entries, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry array indexed by wr_ptr/rd_ptr. Pointers are CNT_W bits wide; the low bits index the array, and the MSB distinguishes full from empty on wrap-around.
- occupancy = wr_ptr - rd_ptr, modulo 2^CNT_W. It is derived from registered pointers, never from inputs.
- in_ready = (occupancy != DEPTH). It has no combinational dependence on out_ready or in_valid.
- push = in_valid & in_ready & ~flush. Writes entry[wr_ptr] and increments wr_ptr at the edge.
- out_valid = (occupancy != 0) & ~flush. out_* = entry[rd_ptr]. Data is stable while out_valid=1 and out_ready=0.
- pop = out_valid & out_ready. Increments rd_ptr at the edge.
- Simultaneous push and pop: both pointers advance and occupancy is unchanged. This applies at every occupancy from 1 to DEPTH-1.
  - When full, push cannot occur even if a pop occurs that same cycle (no pop-through-full).
- Empty: out_valid=0. A push makes the entry visible on the next cycle, so minimum latency in->out is 1 cycle.
- Wrap-around: pointers wrap modulo 2^CNT_W with no special casing. FIFO ordering is preserved across the wrap.
- Flush: takes priority over push and pop.
  - In the flush cycle: out_valid=0 and the incoming request is discarded (in_ready may still read 1).
  - At the edge: rd_ptr <= wr_ptr, so occupancy is 0 from the next cycle.
- Reset (asynchronous, any time, including mid-transfer): wr_ptr=rd_ptr=0, occupancy=0, out_valid=0, in_ready=1 once rst deasserts. Entry contents are not reset; out_* data is don't-care while out_valid=0.
- No other state; no state machine beyond pointer arithmetic.

Optional Feature:
- Macro XCTCMSG_ISSUE_QUEUE_BYPASS_EN.
- Defined: when occupancy==0 and ~flush, the queue is transparent.
  - out_valid = in_valid and out_* = in_*.
  - If out_ready=1 the request goes straight through; it is not written and the pointers do not move (0-cycle latency).
  - If out_ready=0 it is written normally.
  - in_ready is still occupancy-based only.
- Undefined: no bypass. Every request spends at least one cycle in the array.

Test Plan:
- Reset then single request: funct3=3'b001, rs1=64'h1234, out_ready=1.
  - Macro off: out_valid=1 the cycle after the push, with identical fields; occupancy returns 1->0.
  - Macro on: out_valid=1 the same cycle, occupancy stays 0.
- Fill with out_ready=0: push 4 requests with rs1 = 1..4. occupancy=4, in_ready=0; a 5th in_valid is not accepted. Then out_ready=1 drains rs1 = 1,2,3,4 in order.
- Wrap-around: push and pop continuously for 10 requests (rs1 = 0..9) at occupancy 2. Output order is 0..9, occupancy holds at 2, and no entry is lost across the pointer wrap.
- Flush: occupancy=3 and in_valid=1 with flush=1. out_valid=0 that cycle; occupancy=0 next cycle; the incoming request never appears on out.
- Async reset mid-stream: assert rst between clock edges at occupancy=2. out_valid and occupancy go to 0 immediately without a clock edge. After deassert, in_ready=1.
- Stall stability: head rs2=64'hDEAD with out_ready=0 for 5 cycles while pushes continue. out_* is unchanged all 5 cycles.
